glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Consumes the configuration and strobe outputs of the UART command handler.
- Generates the timed glitch pulse train (glitch_o) and the optional target reset (target_rst_o).
- Runs either immediately on command, or after an armed external trigger edge.
- Sits between the command handler and the glitch output driver/pad logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages of the trigger_i synchroniser (minimum 2)
TRIG_RISING, 1, 1 = fire on trigger rising edge, 0 = fire on falling edge

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
trigger_i  input  1  asynchronous external trigger from target
delay_i  input  16  cycles from start event to first pulse
width_i  input  8  pulse high time, cycles
num_pulses_i  input  8  number of pulses
pulse_spacing_i  input  16  low time between pulses, cycles
reset_length_i  input  16  target reset assertion length, cycles
pulse_en_i  input  1  one-cycle strobe: start sequence now
reset_en_i  input  1  one-cycle strobe: reset target, then run sequence
arm_i  input  1  one-cycle strobe: wait for trigger edge
glitch_o  output  1  registered glitch pulse output
target_rst_o  output  1  registered target reset, active-high
armed_o  output  1  high while waiting for trigger
busy_o  output  1  high while a sequence runs (RESET/DELAY/PULSE/GAP)
done_o  output  1  one-cycle strobe at end of sequence

Behaviour:
- Reset: every output is 0, the state is IDLE, and the synchroniser and all counters clear.
- rst asserted mid-sequence: glitch_o and target_rst_o are 0 from the first clock edge at which rst is sampled high.
- All outputs are registered.
- States: IDLE, ARMED, RESET, DELAY, PULSE, GAP.
- Configuration latch:
  - delay, width, num_pulses, spacing and reset_length are copied into internal registers in the start cycle.
  - Input changes during a running sequence have no effect.
- IDLE, strobe priority when several arrive in one cycle: reset_en_i > pulse_en_i > arm_i.
- Start cycle N is defined as one of:
  - the cycle in which pulse_en_i is sampled high, or
  - the cycle a trigger edge is detected in ARMED.
- Start event from pulse_en or trigger: DELAY is entered; glitch_o is first high in cycle N+1+delay.
- reset_en_i in IDLE (cycle N), when the latched reset_length L > 0:
  - target_rst_o is high in cycles N+1 .. N+L.
  - DELAY then runs; glitch_o is first high in cycle N+1+L+delay.
- reset_en_i with L = 0: behaves exactly as pulse_en_i.
- arm_i in IDLE: ARMED, with armed_o = 1 from the next cycle.
  - In ARMED, a detected trigger edge is the start event; armed_o falls as busy_o rises.
  - pulse_en_i in ARMED starts the sequence and disarms.
  - reset_en_i in ARMED is ignored.
  - arm_i in ARMED keeps it armed.
- Trigger detection:
  - trigger_i passes through SYNC_STAGES flops, then an edge detector on the last two synchronised bits.
  - Edges occurring outside ARMED are discarded (no queuing).
- Pulse train:
  - P = num_pulses, W = width, S' = max(pulse_spacing, 1).
  - Each pulse is W cycles high; consecutive pulses are separated by S' cycles low.
  - Spacing 0 is forced to 1 so that pulses never merge.
- Degenerate cases: P = 0 or W = 0 means no pulse is emitted; the sequence ends when DELAY expires.
- done_o:
  - High for exactly one cycle, in the cycle after the final high cycle of glitch_o.
  - With no pulses, high in the cycle DELAY would have produced the first pulse.
  - Timing: done at N+1+L+delay+P*W+(P-1)*S' (L = 0 when not a reset start).
  - In the done_o cycle the state is IDLE and busy_o = 0.
- Strobes while busy_o = 1 are ignored.
- Width rules:
  - Delay, spacing and reset counters are 16-bit; width and pulse counters are 8-bit.
  - Max values (65535, 255) must work without wrap.
- busy_o: 1 in RESET/DELAY/PULSE/GAP, otherwise 0.

Test Plan:
- Plain sequence: delay=3, width=2, num=3, spacing=4, pulse_en at cycle 0 -> glitch_o high in cycles 4–5, 10–11, 16–17; done_o at cycle 18; busy_o in cycles 1–17.
- Reset start: reset_length=5, delay=0, width=1, num=1, reset_en at cycle 0 -> target_rst_o high in cycles 1–5; glitch_o high in cycle 6; done_o at cycle 7.
- Armed trigger: arm, then trigger_i rising edge -> armed_o cleared; glitch_o starts delay+1 cycles after edge detection (SYNC_STAGES+1 cycles after the pin edge). A second edge during the run produces no second sequence.
- Degenerate values:
  - spacing=0, width=1, num=2, delay=0 -> pulses in cycles 1 and 3, low in cycle 2.
  - num=0, delay=2 -> no glitch; done_o at cycle 3.
- Robustness, part 1: pulse_en while busy is ignored; delay_i changed mid-run has no effect on the current run.
- Robustness, part 2: rst asserted during PULSE -> glitch_o is 0 at the next edge, all outputs are 0, and state is IDLE. Simultaneous reset_en and pulse_en with L=2 -> a reset sequence is run.
- Max values: delay=65535, num=255, width=255, pulse_en at cycle 0 -> done_o timing matches the formula, with no counter wrap.

Source files
------------

// File: rtl/glitch_sequencer.sv
// Timed glitch pulse-train generator: runs on command or on an armed trigger edge,
// with an optional target reset phase ahead of the programmed delay.
module glitch_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter bit TRIG_RISING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic [15:0] reset_length_i,
  input  logic        pulse_en_i,
  input  logic        reset_en_i,
  input  logic        arm_i,
  output logic        glitch_o,
  output logic        target_rst_o,
  output logic        armed_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_RESET = 3'd2;
  localparam logic [2:0] S_DELAY = 3'd3;
  localparam logic [2:0] S_PULSE = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]             state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   trig_prev_reg;
  logic                   trig_sync, trig_edge;

  logic [15:0] delay_reg, delay_next;
  logic [7:0]  width_reg, width_next;
  logic [7:0]  num_reg, num_next;
  logic [15:0] spacing_reg, spacing_next;

  // One 16-bit counter is shared by the RESET, DELAY and GAP phases.
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  wcnt_reg, wcnt_next;
  logic [7:0]  pcnt_reg, pcnt_next;

  logic glitch_reg, glitch_next;
  logic trst_reg, trst_next;
  logic armed_reg, busy_reg, done_reg, done_next;

  logic        in_start, launch, fire, latch, has_pulses;
  logic [15:0] eff_delay;
  logic [7:0]  eff_width, eff_num;

  assign trig_sync = sync_reg[SYNC_STAGES-1];
  assign trig_edge = TRIG_RISING ? (trig_sync & ~trig_prev_reg) : (~trig_sync & trig_prev_reg);

  // Launches out of IDLE/ARMED see the live inputs (latched this same cycle);
  // launches out of RESET and DELAY see the latched copy.
  assign in_start   = (state_reg == S_IDLE) || (state_reg == S_ARMED);
  assign eff_delay  = in_start ? delay_i      : delay_reg;
  assign eff_width  = in_start ? width_i      : width_reg;
  assign eff_num    = in_start ? num_pulses_i : num_reg;
  assign has_pulses = (eff_width != 8'd0) && (eff_num != 8'd0);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wcnt_next    = wcnt_reg;
    pcnt_next    = pcnt_reg;
    glitch_next  = 1'b0;
    trst_next    = 1'b0;
    done_next    = 1'b0;
    launch       = 1'b0;
    fire         = 1'b0;
    latch        = 1'b0;
    delay_next   = delay_reg;
    width_next   = width_reg;
    num_next     = num_reg;
    spacing_next = spacing_reg;

    case (state_reg)
      S_IDLE: begin
        if (reset_en_i && (reset_length_i != 16'd0)) begin
          latch      = 1'b1;
          state_next = S_RESET;
          cnt_next   = reset_length_i;
          trst_next  = 1'b1;
        end else if (reset_en_i || pulse_en_i) begin
          latch  = 1'b1;
          launch = 1'b1;
        end else if (arm_i) begin
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (pulse_en_i || trig_edge) begin
          latch  = 1'b1;
          launch = 1'b1;
        end
      end
      S_RESET: begin
        if (cnt_reg == 16'd1) begin
          launch = 1'b1;
        end else begin
          cnt_next  = cnt_reg - 16'd1;
          trst_next = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt_reg == 16'd1) fire = 1'b1;
        else cnt_next = cnt_reg - 16'd1;
      end
      S_PULSE: begin
        if (wcnt_reg == 8'd1) begin
          if (pcnt_reg == 8'd1) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = S_GAP;
            cnt_next   = spacing_reg;
          end
        end else begin
          wcnt_next   = wcnt_reg - 8'd1;
          glitch_next = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_reg == 16'd1) begin
          state_next  = S_PULSE;
          glitch_next = 1'b1;
          wcnt_next   = width_reg;
          pcnt_next   = pcnt_reg - 8'd1;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (launch) begin
      if (eff_delay != 16'd0) begin
        state_next = S_DELAY;
        cnt_next   = eff_delay;
      end else begin
        fire = 1'b1;
      end
    end

    if (fire) begin
      if (has_pulses) begin
        state_next  = S_PULSE;
        glitch_next = 1'b1;
        wcnt_next   = eff_width;
        pcnt_next   = eff_num;
      end else begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
    end

    if (latch) begin
      delay_next   = delay_i;
      width_next   = width_i;
      num_next     = num_pulses_i;
      // A zero gap is stretched to one cycle so adjacent pulses stay distinct.
      spacing_next = (pulse_spacing_i == 16'd0) ? 16'd1 : pulse_spacing_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      sync_reg      <= '0;
      trig_prev_reg <= 1'b0;
      delay_reg     <= '0;
      width_reg     <= '0;
      num_reg       <= '0;
      spacing_reg   <= '0;
      cnt_reg       <= '0;
      wcnt_reg      <= '0;
      pcnt_reg      <= '0;
      glitch_reg    <= 1'b0;
      trst_reg      <= 1'b0;
      armed_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], trigger_i};
      trig_prev_reg <= trig_sync;
      delay_reg     <= delay_next;
      width_reg     <= width_next;
      num_reg       <= num_next;
      spacing_reg   <= spacing_next;
      cnt_reg       <= cnt_next;
      wcnt_reg      <= wcnt_next;
      pcnt_reg      <= pcnt_next;
      glitch_reg    <= glitch_next;
      trst_reg      <= trst_next;
      armed_reg     <= (state_next == S_ARMED);
      busy_reg      <= (state_next == S_RESET) || (state_next == S_DELAY) ||
                       (state_next == S_PULSE) || (state_next == S_GAP);
      done_reg      <= done_next;
    end
  end

  assign glitch_o     = glitch_reg;
  assign target_rst_o = trst_reg;
  assign armed_o      = armed_reg;
  assign busy_o       = busy_reg;
  assign done_o       = done_reg;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench: a timeline model (start cycle + closed-form pulse schedule)
// predicts every output each cycle; directed cases also pin absolute timings.
module tb_glitch_sequencer;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trigger_i = 1'b0, pulse_en_i = 1'b0, reset_en_i = 1'b0, arm_i = 1'b0;
  logic [15:0] delay_i = '0, pulse_spacing_i = '0, reset_length_i = '0;
  logic [7:0]  width_i = '0, num_pulses_i = '0;
  logic glitch_o, target_rst_o, armed_o, busy_o, done_o;

  always #5 clk = ~clk;

  glitch_sequencer #(.SYNC_STAGES(SYNC), .TRIG_RISING(1'b1)) dut (
    .clk(clk), .rst(rst), .trigger_i(trigger_i),
    .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
    .pulse_spacing_i(pulse_spacing_i), .reset_length_i(reset_length_i),
    .pulse_en_i(pulse_en_i), .reset_en_i(reset_en_i), .arm_i(arm_i),
    .glitch_o(glitch_o), .target_rst_o(target_rst_o), .armed_o(armed_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0, errors = 0;
  longint cyc = 0;
  bit cmp_en = 1'b0;
  bit trig_lvl = 1'b0;
  bit trig_hist [0:131071];

  // Model of the current/last run: start cycle, reset length, schedule and done time.
  bit     m_valid = 1'b0, m_armed = 1'b0;
  longint m_n0, m_td, m_p0, m_l, m_w, m_p, m_s;
  longint m_last_rst = -100;

  logic e_g, e_t, e_a, e_b, e_d;
  longint first_g, last_done, g_count, t_count;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit run_busy(input longint c);
    return m_valid && (c > m_n0) && (c < m_td);
  endfunction

  function automatic bit sync_at(input longint c);
    if (c - SYNC <= m_last_rst) return 1'b0;
    return trig_hist[c - SYNC];
  endfunction

  function automatic bit trig_edge_at(input longint c);
    bit prev;
    prev = (c - 1 > m_last_rst) ? sync_at(c - 1) : 1'b0;
    return sync_at(c) && !prev;
  endfunction

  task automatic eval(input longint c);
    e_b = run_busy(c);
    e_d = m_valid && (c == m_td);
    e_t = m_valid && (c > m_n0) && (c <= m_n0 + m_l);
    e_a = m_armed;
    e_g = 1'b0;
    if (m_valid && m_p > 0 && m_w > 0 && c >= m_p0 && c < m_td)
      e_g = ((c - m_p0) % (m_w + m_s)) < m_w;
  endtask

  task automatic start_run(input longint c, input longint l);
    m_valid = 1'b1;
    m_n0 = c;
    m_l  = l;
    m_w  = width_i;
    m_p  = num_pulses_i;
    m_s  = (pulse_spacing_i == 16'd0) ? 1 : pulse_spacing_i;
    m_p0 = c + 1 + l + delay_i;
    m_td = m_p0 + ((m_p > 0 && m_w > 0) ? (m_p * m_w + (m_p - 1) * m_s) : 0);
    $display("run start=%0d rst_len=%0d delay=%0d width=%0d num=%0d gap=%0d done_at=%0d",
             c, l, delay_i, m_w, m_p, m_s, m_td);
  endtask

  task automatic model_update(input longint c, input bit pe, input bit re, input bit ar, input bit r);
    if (r) begin
      m_valid = 1'b0;
      m_armed = 1'b0;
      m_last_rst = c;
    end else if (!run_busy(c)) begin
      if (m_armed) begin
        if (pe || trig_edge_at(c)) begin
          m_armed = 1'b0;
          start_run(c, 0);
        end
      end else if (re) start_run(c, reset_length_i);
      else if (pe) start_run(c, 0);
      else if (ar) m_armed = 1'b1;
    end
  endtask

  task automatic step(input bit pe, input bit re, input bit ar, input bit r);
    eval(cyc);
    pulse_en_i = pe;
    reset_en_i = re;
    arm_i      = ar;
    rst        = r;
    trigger_i  = trig_lvl;
    trig_hist[cyc] = trig_lvl;
    model_update(cyc, pe, re, ar, r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input int d, input int w, input int n, input int s, input int l);
    delay_i = 16'(d);
    width_i = 8'(w);
    num_pulses_i = 8'(n);
    pulse_spacing_i = 16'(s);
    reset_length_i = 16'(l);
  endtask

  task automatic clear_obs();
    first_g = -1; last_done = -1; g_count = 0; t_count = 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("glitch_o", glitch_o, e_g);
      chk("target_rst_o", target_rst_o, e_t);
      chk("armed_o", armed_o, e_a);
      chk("busy_o", busy_o, e_b);
      chk("done_o", done_o, e_d);
      if (glitch_o === 1'b1) begin
        g_count++;
        if (first_g < 0) first_g = cyc;
      end
      if (target_rst_o === 1'b1) t_count++;
      if (done_o === 1'b1) last_done = cyc;
    end
  end

  initial begin
    longint t0;
    clear_obs();
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    idle(3);
    chk("reset_glitch", glitch_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);

    // Plain sequence
    set_cfg(3, 2, 3, 4, 0); clear_obs(); t0 = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(22);
    chk_int("plain_first_glitch", first_g - t0, 4);
    chk_int("plain_done", last_done - t0, 18);
    chk_int("plain_glitch_cycles", g_count, 6);

    // Reset start
    set_cfg(0, 1, 1, 0, 5); clear_obs(); t0 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b0); idle(10);
    chk_int("rststart_trst_cycles", t_count, 5);
    chk_int("rststart_first_glitch", first_g - t0, 6);
    chk_int("rststart_done", last_done - t0, 7);

    // Armed trigger, then a second edge mid-run
    set_cfg(2, 3, 2, 2, 0); clear_obs();
    step(1'b0, 1'b0, 1'b1, 1'b0); idle(4);
    t0 = cyc; trig_lvl = 1'b1; idle(6);
    trig_lvl = 1'b0; idle(2); trig_lvl = 1'b1; idle(25);
    chk_int("armed_first_glitch", first_g - t0, SYNC + 1 + 2);
    chk_int("armed_glitch_cycles", g_count, 6);
    trig_lvl = 1'b0; idle(5);

    // Zero spacing stretched to one
    set_cfg(0, 1, 2, 0, 0); clear_obs(); t0 = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(8);
    chk_int("gap0_first_glitch", first_g - t0, 1);
    chk_int("gap0_glitch_cycles", g_count, 2);
    chk_int("gap0_done", last_done - t0, 4);

    // No pulses
    set_cfg(2, 1, 0, 0, 0); clear_obs(); t0 = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(6);
    chk_int("nopulse_glitch_cycles", g_count, 0);
    chk_int("nopulse_done", last_done - t0, 3);

    // Strobe and config change while busy
    set_cfg(5, 2, 2, 3, 0); clear_obs(); t0 = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(2);
    delay_i = 16'd1;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(15);
    chk_int("busy_ignore_done", last_done - t0, 13);

    // rst during PULSE
    set_cfg(1, 10, 1, 0, 0); clear_obs();
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_glitch", glitch_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    idle(3);

    // reset_en and pulse_en together: reset sequence wins
    set_cfg(0, 1, 1, 0, 2); clear_obs(); t0 = cyc;
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(6);
    chk_int("both_trst_cycles", t_count, 2);
    chk_int("both_first_glitch", first_g - t0, 3);

    // Maximum delay
    set_cfg(65535, 1, 1, 0, 0); clear_obs(); t0 = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(65540);
    chk_int("maxdelay_done", last_done - t0, 65537);

    // Maximum width
    set_cfg(0, 255, 2, 3, 0); clear_obs(); t0 = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(520);
    chk_int("maxwidth_done", last_done - t0, 514);
    chk_int("maxwidth_glitch_cycles", g_count, 510);

    // Maximum pulse count
    set_cfg(0, 1, 255, 0, 0); clear_obs(); t0 = cyc;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(515);
    chk_int("maxnum_done", last_done - t0, 510);
    chk_int("maxnum_glitch_cycles", g_count, 255);

    // Randomised traffic, model checked every cycle
    for (int i = 0; i < 4000; i++) begin
      set_cfg($urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 5));
      if ($urandom_range(0, 14) == 0) trig_lvl = ~trig_lvl;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
    end
    trig_lvl = 1'b0;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
